// File: rtl/regfile_arbiter_if.sv
// Bundles both requester channels and the register-file port of regfile_arbiter.
// The arbiter uses the slave modport; a client/bench side uses master.
interface regfile_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int ADDRW = 5
);
    logic             req_a;
    logic             wr_a;
    logic [ADDRW-1:0] addr_a1;
    logic [ADDRW-1:0] addr_a2;
    logic [WIDTH-1:0] wdata_a;
    logic             ack_a;
    logic [WIDTH-1:0] rdata_a1;
    logic [WIDTH-1:0] rdata_a2;

    logic             req_b;
    logic             wr_b;
    logic [ADDRW-1:0] addr_b1;
    logic [ADDRW-1:0] addr_b2;
    logic [WIDTH-1:0] wdata_b;
    logic             ack_b;
    logic [WIDTH-1:0] rdata_b1;
    logic [WIDTH-1:0] rdata_b2;

    logic [WIDTH-1:0] rf_read_data1;
    logic [WIDTH-1:0] rf_read_data2;
    logic [ADDRW-1:0] rf_read_reg1;
    logic [ADDRW-1:0] rf_read_reg2;
    logic [ADDRW-1:0] rf_write_reg;
    logic [WIDTH-1:0] rf_write_data;
    logic             rf_reg_write;
    logic             busy;

    modport slave (
        input  req_a, wr_a, addr_a1, addr_a2, wdata_a,
        input  req_b, wr_b, addr_b1, addr_b2, wdata_b,
        input  rf_read_data1, rf_read_data2,
        output ack_a, rdata_a1, rdata_a2,
        output ack_b, rdata_b1, rdata_b2,
        output rf_read_reg1, rf_read_reg2, rf_write_reg, rf_write_data, rf_reg_write,
        output busy
    );

    modport master (
        output req_a, wr_a, addr_a1, addr_a2, wdata_a,
        output req_b, wr_b, addr_b1, addr_b2, wdata_b,
        output rf_read_data1, rf_read_data2,
        input  ack_a, rdata_a1, rdata_a2,
        input  ack_b, rdata_b1, rdata_b2,
        input  rf_read_reg1, rf_read_reg2, rf_write_reg, rf_write_data, rf_reg_write,
        input  busy
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Shares one 2-read/1-write register file between requesters A and B.
// Each transaction walks IDLE -> ISSUE -> ACK; every output is registered.
module regfile_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDRW      = 5,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    regfile_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             gnt_q, gnt_d;
    logic             wr_q, wr_d;

    logic             ack_a_q, ack_a_d;
    logic             ack_b_q, ack_b_d;
    logic [WIDTH-1:0] rdata_a1_q, rdata_a1_d;
    logic [WIDTH-1:0] rdata_a2_q, rdata_a2_d;
    logic [WIDTH-1:0] rdata_b1_q, rdata_b1_d;
    logic [WIDTH-1:0] rdata_b2_q, rdata_b2_d;

    logic [ADDRW-1:0] rf_rd1_q, rf_rd1_d;
    logic [ADDRW-1:0] rf_rd2_q, rf_rd2_d;
    logic [ADDRW-1:0] rf_wreg_q, rf_wreg_d;
    logic [WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic             rf_we_q, rf_we_d;
    logic             busy_q, busy_d;

    // Winner selection and a view of the winning request's fields.
    logic             sel_b;
    logic             sel_wr;
    logic [ADDRW-1:0] sel_a1;
    logic [ADDRW-1:0] sel_a2;
    logic [WIDTH-1:0] sel_wd;

    always_comb begin
        sel_b = 1'b0;
        if (bus.req_a && bus.req_b) begin
            sel_b = FIXED_PRIO ? 1'b0 : ptr_q;
        end else if (bus.req_b) begin
            sel_b = 1'b1;
        end
        sel_wr = sel_b ? bus.wr_b    : bus.wr_a;
        sel_a1 = sel_b ? bus.addr_b1 : bus.addr_a1;
        sel_a2 = sel_b ? bus.addr_b2 : bus.addr_a2;
        sel_wd = sel_b ? bus.wdata_b : bus.wdata_a;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        wr_d       = wr_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        rdata_a1_d = rdata_a1_q;
        rdata_a2_d = rdata_a2_q;
        rdata_b1_d = rdata_b1_q;
        rdata_b2_d = rdata_b2_q;
        rf_rd1_d   = rf_rd1_q;
        rf_rd2_d   = rf_rd2_q;
        rf_wreg_d  = rf_wreg_q;
        rf_wdata_d = rf_wdata_q;
        rf_we_d    = rf_we_q;
        busy_d     = busy_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    gnt_d    = sel_b;
                    wr_d     = sel_wr;
                    rf_rd1_d = sel_a1;
                    rf_rd2_d = sel_wr ? sel_a1 : sel_a2;
                    if (sel_wr) begin
                        rf_wreg_d  = sel_a1;
                        rf_wdata_d = sel_wd;
                        // r0 is hard-wired zero: the write is dropped but still acked.
                        rf_we_d    = (sel_a1 != '0);
                    end
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (!wr_q) begin
                    if (gnt_q) begin
                        rdata_b1_d = bus.rf_read_data1;
                        rdata_b2_d = bus.rf_read_data2;
                    end else begin
                        rdata_a1_d = bus.rf_read_data1;
                        rdata_a2_d = bus.rf_read_data2;
                    end
                end
                ack_a_d    = ~gnt_q;
                ack_b_d    = gnt_q;
                rf_rd1_d   = '0;
                rf_rd2_d   = '0;
                rf_wreg_d  = '0;
                rf_wdata_d = '0;
                rf_we_d    = 1'b0;
                ptr_d      = ~gnt_q;
                state_d    = S_ACK;
            end

            S_ACK: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= 1'b0;
            gnt_q      <= 1'b0;
            wr_q       <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            rdata_a1_q <= '0;
            rdata_a2_q <= '0;
            rdata_b1_q <= '0;
            rdata_b2_q <= '0;
            rf_rd1_q   <= '0;
            rf_rd2_q   <= '0;
            rf_wreg_q  <= '0;
            rf_wdata_q <= '0;
            rf_we_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            wr_q       <= wr_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            rdata_a1_q <= rdata_a1_d;
            rdata_a2_q <= rdata_a2_d;
            rdata_b1_q <= rdata_b1_d;
            rdata_b2_q <= rdata_b2_d;
            rf_rd1_q   <= rf_rd1_d;
            rf_rd2_q   <= rf_rd2_d;
            rf_wreg_q  <= rf_wreg_d;
            rf_wdata_q <= rf_wdata_d;
            rf_we_q    <= rf_we_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.ack_a         = ack_a_q;
    assign bus.ack_b         = ack_b_q;
    assign bus.rdata_a1      = rdata_a1_q;
    assign bus.rdata_a2      = rdata_a2_q;
    assign bus.rdata_b1      = rdata_b1_q;
    assign bus.rdata_b2      = rdata_b2_q;
    assign bus.rf_read_reg1  = rf_rd1_q;
    assign bus.rf_read_reg2  = rf_rd2_q;
    assign bus.rf_write_reg  = rf_wreg_q;
    assign bus.rf_write_data = rf_wdata_q;
    assign bus.rf_reg_write  = rf_we_q;
    assign bus.busy          = busy_q;

endmodule
